lfm_pulse_tx: RTL and testbench
===============================

LFM_PULSE_TX -- requirements
Module: lfm_pulse_tx

Interface
REQ-001 Parameter WIDTH, default 12: DAC/sample width in bits.
REQ-002 Parameter PRF_N, default 16: number of pulses per coherent group.
REQ-003 Parameter PULSE_LEN, default 512: transmitted samples per pulse (6.4 us at 80 MHz).
REQ-004 Parameter PRI_LEN, default 8000: clocks per pulse repetition interval; SHALL satisfy PRI_LEN > PULSE_LEN.
REQ-005 Parameter PHASE_W, default 32: phase and frequency accumulator width.
REQ-006 Parameter F_START, default 32'h5000_0000: start frequency word (25 MHz at 80 MHz).
REQ-007 Parameter K_RATE, default 32'h0010_0000: per-sample frequency increment (10 MHz sweep over 512 samples).
REQ-008 clk  in  1  sample clock; all logic on its rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 start  in  1  request a pulse group; honoured only in IDLE.
REQ-011 stop  in  1  abort the group; honoured in any state.
REQ-012 tx_I  out  WIDTH signed  cosine sample.
REQ-013 tx_Q  out  WIDTH signed  sine sample.
REQ-014 tx_valid  out  1  high while tx_I/tx_Q carry a pulse sample.
REQ-015 dac_code  out  WIDTH+2  {2'b00, tx_I + 2^(WIDTH-1)}, offset binary for the DAC.
REQ-016 pulse_start  out  1  one-cycle strobe coincident with the first valid sample of each pulse (receiver sync).
REQ-017 pulse_idx  out  clog2(PRF_N)  index of the current pulse within the group.
REQ-018 group_done  out  1  one-cycle strobe when the last PRI of the group ends.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, TX, LISTEN, DONE.
REQ-021 IDLE -> TX on start=1 and stop=0; pri_cnt=0, pulse_idx=0, phase=0, freq=F_START.
REQ-022 TX SHALL advance pri_cnt every cycle; TX -> LISTEN when pri_cnt = PULSE_LEN-1.
REQ-023 LISTEN -> TX when pri_cnt = PRI_LEN-1 and pulse_idx < PRF_N-1; pri_cnt wraps to 0, pulse_idx increments, phase and freq reload.
REQ-024 LISTEN -> DONE when pri_cnt = PRI_LEN-1 and pulse_idx = PRF_N-1; DONE -> IDLE unconditionally after one cycle.
REQ-025 In TX, per sample: phase <= phase + freq and freq <= freq + K_RATE, both modulo 2^PHASE_W (wrap is legal).
REQ-026 The LUT address SHALL be the top 10 phase bits; amplitude = round((2^(WIDTH-1)-1) * cos/sin(2*pi*addr/1024)).
REQ-027 Output latency SHALL be 2 cycles: the sample computed in the first TX cycle appears with tx_valid=1 on the second rising edge after start is sampled.
REQ-028 tx_valid SHALL be high for exactly PULSE_LEN consecutive cycles per pulse; pulse starts are exactly PRI_LEN cycles apart.
REQ-029 When tx_valid=0, tx_I=tx_Q=0 and dac_code=2^(WIDTH-1).
REQ-030 group_done SHALL pulse in the DONE cycle; start in that cycle is ignored.
REQ-031 start while busy=1 SHALL be ignored with no effect.
REQ-032 stop SHALL force IDLE on the next edge and flush the output pipeline, so tx_valid=0 from the next edge; no group_done; stop wins over a simultaneous start.

Reset
REQ-033 With rst=1: state=IDLE; pri_cnt=0, pulse_idx=0, phase=0, freq=F_START; tx_I=tx_Q=0, tx_valid=0, pulse_start=0, group_done=0, busy=0, dac_code=2^(WIDTH-1).
REQ-034 rst mid-group SHALL behave as stop, and rst SHALL take priority over start and stop.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the LUT depth/address width (1024/10), and the default F_START/K_RATE constants.
REQ-036 Sine/cosine lookup SHALL be one sub-module, tx_sincos_lut: quarter-wave ROM, 1-cycle registered output, returns both cos and sin.

Verification
REQ-037 Use WIDTH=12, PRF_N=2, PULSE_LEN=8, PRI_LEN=20, F_START=32'h4000_0000, K_RATE=0; start at edge 0 -> tx_valid on edges 2..9 and 22..29; tx_I = 2047,0,-2047,0 repeating; tx_Q = 0,2047,0,-2047 repeating; pulse_start at edges 2 and 22; pulse_idx 0 then 1; group_done once; busy low afterwards.
REQ-038 Same parameters, K_RATE=32'h0400_0000 -> the phase-accumulator sequence equals the double-sum reference model, including 32-bit wrap; outputs match the LUT model bit-exactly.
REQ-039 start held high continuously -> back-to-back groups each begin only after a DONE/IDLE cycle; start pulses while busy do not shift timing.
REQ-040 stop at edge 5, then at edge 15 -> tx_valid=0 from edge 6; no group_done; dac_code=2048; a new start restarts at pulse_idx=0 with the first sample 2047/0.
REQ-041 rst=1 for one cycle inside LISTEN, plus start and stop asserted together in IDLE -> full reset values per REQ-033; stop wins and busy stays 0.
REQ-042 A sample with tx_I=-2047 -> dac_code=1; tx_I=2047 -> dac_code=4095; the top two dac_code bits are always 0.

Source files
------------

// File: rtl/lfm_pulse_tx_pkg.sv
// Shared constants for the LFM pulse transmitter: FSM encoding, sin/cos LUT geometry
// and the default chirp start frequency / sweep rate.
package lfm_pulse_tx_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_TX     = 2'd1;
   localparam logic [1:0] ST_LISTEN = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam int LUT_DEPTH = 1024;
   localparam int LUT_AW    = 10;
   localparam int QTR_DEPTH = LUT_DEPTH / 4;

   localparam logic [31:0] F_START_DEF = 32'h5000_0000;
   localparam logic [31:0] K_RATE_DEF  = 32'h0010_0000;

   localparam real PI_R = 3.14159265358979323846;

   // Quarter-wave sample k of a full-scale sine, rounded to nearest; evaluated once per ROM entry.
   function automatic int qtr_amp(input int k, input int amp_max);
      real ang;
      ang = PI_R * real'(k) / real'(2 * QTR_DEPTH);
      return $rtoi(real'(amp_max) * $sin(ang) + 0.5);
   endfunction

endpackage

// File: rtl/lfm_pulse_tx_if.sv
// Control and sample bus of the LFM pulse transmitter; the transmitter is the slave side.
interface lfm_pulse_tx_if #(
   parameter int WIDTH = 12,
   parameter int IDX_W = 4
);
   logic                    start;
   logic                    stop;
   logic signed [WIDTH-1:0] tx_I;
   logic signed [WIDTH-1:0] tx_Q;
   logic                    tx_valid;
   logic [WIDTH+1:0]        dac_code;
   logic                    pulse_start;
   logic [IDX_W-1:0]        pulse_idx;
   logic                    group_done;
   logic                    busy;

   modport master (
      output start, stop,
      input  tx_I, tx_Q, tx_valid, dac_code, pulse_start, pulse_idx, group_done, busy
   );

   modport slave (
      input  start, stop,
      output tx_I, tx_Q, tx_valid, dac_code, pulse_start, pulse_idx, group_done, busy
   );
endinterface

// File: rtl/lfm_pulse_tx_sincos_lut.sv
// Quarter-wave sin/cos ROM with a registered output: one address in, cos and sin out
// one clock later.
module tx_sincos_lut
   import lfm_pulse_tx_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic                    clk,
   input  logic [LUT_AW-1:0]       i_addr,
   output logic signed [WIDTH-1:0] o_cos,
   output logic signed [WIDTH-1:0] o_sin
);

   localparam int MAG_W   = WIDTH - 1;
   localparam int QW      = LUT_AW - 2;
   localparam int AMP_MAX = (2 ** (WIDTH - 1)) - 1;
   localparam logic [QW:0]       QTR_V   = {1'b1, {QW{1'b0}}};
   localparam logic [LUT_AW-1:0] COS_OFS = {2'b01, {QW{1'b0}}};

   // One extra entry holds the peak so the mirrored quadrants need no special case.
   logic [MAG_W-1:0]  w_rom [0:QTR_DEPTH];
   logic [LUT_AW-1:0] w_cos_addr;

   for (genvar k = 0; k <= QTR_DEPTH; k++) begin : g_rom
      assign w_rom[k] = MAG_W'(qtr_amp(k, AMP_MAX));
   end

   function automatic logic signed [WIDTH-1:0] sine_of(input logic [LUT_AW-1:0] a);
      logic [QW:0]             idx;
      logic signed [WIDTH-1:0] mag;
      idx = a[QW] ? (QTR_V - {1'b0, a[QW-1:0]}) : {1'b0, a[QW-1:0]};
      mag = signed'({1'b0, w_rom[idx]});
      return a[LUT_AW-1] ? -mag : mag;
   endfunction

   assign w_cos_addr = i_addr + COS_OFS;

   always_ff @(posedge clk) begin
      o_cos <= sine_of(w_cos_addr);
      o_sin <= sine_of(i_addr);
   end

endmodule

// File: rtl/lfm_pulse_tx.sv
// Coherent group of linear-FM pulses: FSM-timed chirp phase accumulator feeding a sin/cos
// LUT, with a two-stage output pipeline and offset-binary DAC code.
module lfm_pulse_tx
   import lfm_pulse_tx_pkg::*;
#(
   parameter int                 WIDTH     = 12,
   parameter int                 PRF_N     = 16,
   parameter int                 PULSE_LEN = 512,
   parameter int                 PRI_LEN   = 8000,
   parameter int                 PHASE_W   = 32,
   parameter logic [PHASE_W-1:0] F_START   = F_START_DEF,
   parameter logic [PHASE_W-1:0] K_RATE    = K_RATE_DEF
) (
   input  logic          clk,
   input  logic          rst,
   lfm_pulse_tx_if.slave bus
);

   localparam int IDX_W = (PRF_N > 1) ? $clog2(PRF_N) : 1;
   localparam int CNT_W = $clog2(PRI_LEN);
   localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] PRI_END    = CNT_W'(PRI_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_PULSE = IDX_W'(PRF_N - 1);

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_pri_cnt;
   logic [IDX_W-1:0]   r_pulse_idx;
   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] r_freq;

   logic [LUT_AW-1:0]       w_addr_p0;
   logic                    w_vld_p0;
   logic                    w_first_p0;
   logic signed [WIDTH-1:0] w_cos_p1;
   logic signed [WIDTH-1:0] w_sin_p1;
   logic                    r_vld_p1;
   logic                    r_first_p1;
   logic [IDX_W-1:0]        r_idx_p1;
   logic signed [WIDTH-1:0] r_tx_i_p2;
   logic signed [WIDTH-1:0] r_tx_q_p2;
   logic                    r_vld_p2;
   logic                    r_first_p2;
   logic [IDX_W-1:0]        r_idx_p2;

   // Adding half scale to a two's-complement sample is the same as flipping its sign bit.
   function automatic logic [WIDTH+1:0] to_offset_binary(input logic signed [WIDTH-1:0] s);
      return {2'b00, ~s[WIDTH-1], s[WIDTH-2:0]};
   endfunction

   // Stop and reset share one abort path so both drop the group without a group_done.
   always_ff @(posedge clk) begin
      if (rst || bus.stop) begin
         r_state     <= ST_IDLE;
         r_pri_cnt   <= '0;
         r_pulse_idx <= '0;
         r_phase     <= '0;
         r_freq      <= F_START;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state     <= ST_TX;
                  r_pri_cnt   <= '0;
                  r_pulse_idx <= '0;
                  r_phase     <= '0;
                  r_freq      <= F_START;
               end
            end
            ST_TX: begin
               r_pri_cnt <= r_pri_cnt + 1'b1;
               r_phase   <= r_phase + r_freq;
               r_freq    <= r_freq + K_RATE;
               if (r_pri_cnt == PULSE_END) begin
                  r_state <= ST_LISTEN;
               end
            end
            ST_LISTEN: begin
               if (r_pri_cnt == PRI_END) begin
                  r_pri_cnt <= '0;
                  r_phase   <= '0;
                  r_freq    <= F_START;
                  if (r_pulse_idx == LAST_PULSE) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state     <= ST_TX;
                     r_pulse_idx <= r_pulse_idx + 1'b1;
                  end
               end else begin
                  r_pri_cnt <= r_pri_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               r_pulse_idx <= '0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // p0: LUT address is the top of the phase accumulator during TX
   assign w_addr_p0  = r_phase[PHASE_W-1 -: LUT_AW];
   assign w_vld_p0   = (r_state == ST_TX);
   assign w_first_p0 = (r_state == ST_TX) && (r_pri_cnt == '0);

   // p1: registered ROM output
   tx_sincos_lut #(
      .WIDTH (WIDTH)
   ) u_lut (
      .clk    (clk),
      .i_addr (w_addr_p0),
      .o_cos  (w_cos_p1),
      .o_sin  (w_sin_p1)
   );

   always_ff @(posedge clk) begin
      r_idx_p1 <= r_pulse_idx;
   end

   // p2: output registers, forced to zero whenever no pulse sample is present
   always_ff @(posedge clk) begin
      if (rst || bus.stop) begin
         r_vld_p1   <= 1'b0;
         r_first_p1 <= 1'b0;
         r_vld_p2   <= 1'b0;
         r_first_p2 <= 1'b0;
         r_tx_i_p2  <= '0;
         r_tx_q_p2  <= '0;
         r_idx_p2   <= '0;
      end else begin
         r_vld_p1   <= w_vld_p0;
         r_first_p1 <= w_first_p0;
         r_vld_p2   <= r_vld_p1;
         r_first_p2 <= r_first_p1 && r_vld_p1;
         r_tx_i_p2  <= r_vld_p1 ? w_cos_p1 : '0;
         r_tx_q_p2  <= r_vld_p1 ? w_sin_p1 : '0;
         if (r_vld_p1) begin
            r_idx_p2 <= r_idx_p1;
         end
      end
   end

   assign bus.tx_I        = r_tx_i_p2;
   assign bus.tx_Q        = r_tx_q_p2;
   assign bus.tx_valid    = r_vld_p2;
   assign bus.dac_code    = to_offset_binary(r_tx_i_p2);
   assign bus.pulse_start = r_first_p2;
   assign bus.pulse_idx   = r_idx_p2;
   assign bus.group_done  = (r_state == ST_DONE);
   assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lfm_pulse_tx.sv
// Bench for lfm_pulse_tx: two instances (flat tone and chirp) checked every cycle against a
// closed-form timing/phase model, plus directed literal checks.
module tb_lfm_pulse_tx;

   localparam int WIDTH     = 12;
   localparam int PRF_N     = 2;
   localparam int PULSE_LEN = 8;
   localparam int PRI_LEN   = 20;
   localparam int IDX_W     = (PRF_N > 1) ? $clog2(PRF_N) : 1;
   localparam logic [31:0] FS = 32'h4000_0000;
   localparam logic [31:0] K0 = 32'h0000_0000;
   localparam logic [31:0] K1 = 32'h0400_0000;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic stop;

   always #5 clk = ~clk;

   lfm_pulse_tx_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus0 ();
   lfm_pulse_tx_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus1 ();

   assign bus0.start = start;
   assign bus0.stop  = stop;
   assign bus1.start = start;
   assign bus1.stop  = stop;

   lfm_pulse_tx #(
      .WIDTH(WIDTH), .PRF_N(PRF_N), .PULSE_LEN(PULSE_LEN), .PRI_LEN(PRI_LEN),
      .PHASE_W(32), .F_START(FS), .K_RATE(K0)
   ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   lfm_pulse_tx #(
      .WIDTH(WIDTH), .PRF_N(PRF_N), .PULSE_LEN(PULSE_LEN), .PRI_LEN(PRI_LEN),
      .PHASE_W(32), .F_START(FS), .K_RATE(K1)
   ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit m_act   = 1'b0;
   int m_d     = 0;

   // Phase after k chirp samples: sum of F + j*K for j < k, modulo 2^32.
   function automatic logic [31:0] exp_phase(input int k, input logic [31:0] kr);
      logic [63:0] t;
      t = 64'(k) * 64'(FS) + 64'(kr) * 64'(k * (k - 1) / 2);
      return t[31:0];
   endfunction

   function automatic int lut_amp(input logic [9:0] a, input bit want_sin);
      real ang;
      real v;
      ang = 2.0 * 3.14159265358979323846 * real'(a) / 1024.0;
      v   = 2047.0 * (want_sin ? $sin(ang) : $cos(ang));
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(0.5 - v);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_dut(input int u, input logic [31:0] kr,
                            input logic signed [WIDTH-1:0] ai, input logic signed [WIDTH-1:0] aq,
                            input logic av, input logic [WIDTH+1:0] adac, input logic aps,
                            input logic [IDX_W-1:0] aidx, input logic agd, input logic abusy);
      int          off, p, k;
      logic [31:0] ph;
      int          ei, eq, eidx;
      bit          ev, eps;
      ev = 0; eps = 0; ei = 0; eq = 0; eidx = 0;
      if (m_act && m_d >= 2) begin
         off = m_d - 2;
         p   = off / PRI_LEN;
         k   = off % PRI_LEN;
         if (p < PRF_N && k < PULSE_LEN) begin
            ph   = exp_phase(k, kr);
            ev   = 1;
            ei   = lut_amp(ph[31:22], 1'b0);
            eq   = lut_amp(ph[31:22], 1'b1);
            eps  = (k == 0);
            eidx = p;
         end
      end
      chk($sformatf("dut%0d.tx_valid", u), longint'(av), longint'(ev));
      chk($sformatf("dut%0d.tx_I", u), longint'(ai), longint'(ei));
      chk($sformatf("dut%0d.tx_Q", u), longint'(aq), longint'(eq));
      chk($sformatf("dut%0d.dac_code", u), longint'(adac), longint'(ei + 2048));
      chk($sformatf("dut%0d.pulse_start", u), longint'(aps), longint'(eps));
      chk($sformatf("dut%0d.group_done", u), longint'(agd),
          longint'(m_act && (m_d == PRF_N * PRI_LEN)));
      chk($sformatf("dut%0d.busy", u), longint'(abusy), longint'(m_act));
      if (ev) chk($sformatf("dut%0d.pulse_idx", u), longint'(aidx), longint'(eidx));
   endtask

   // One clock: apply inputs, advance the model on the edge, compare 1 time unit later.
   task automatic step(input bit r, input bit s, input bit p);
      rst = r; start = s; stop = p;
      @(posedge clk);
      if (r || p) begin
         m_act = 0;
      end else if (!m_act && s) begin
         m_act = 1;
         m_d   = 0;
      end else if (m_act) begin
         m_d++;
         if (m_d > PRF_N * PRI_LEN) m_act = 0;
      end
      #1;
      cyc++;
      check_dut(0, K0, bus0.tx_I, bus0.tx_Q, bus0.tx_valid, bus0.dac_code, bus0.pulse_start,
                bus0.pulse_idx, bus0.group_done, bus0.busy);
      check_dut(1, K1, bus1.tx_I, bus1.tx_Q, bus1.tx_valid, bus1.dac_code, bus1.pulse_start,
                bus1.pulse_idx, bus1.group_done, bus1.busy);
   endtask

   initial begin
      int lit_i[4];
      int lit_q[4];
      int gd_cnt;
      int ps_cnt;
      lit_i = '{2047, 0, -2047, 0};
      lit_q = '{0, 2047, 0, -2047};

      // Pin the model itself against hand-computed values.
      chk("model.phase_k3", longint'(exp_phase(3, K1)), longint'(32'hCC00_0000));
      chk("model.phase_k7_wrap", longint'(exp_phase(7, K1)), longint'(32'h1400_0000));
      chk("model.cos0", lut_amp(10'd0, 1'b0), 2047);
      chk("model.cos512", lut_amp(10'd512, 1'b0), -2047);
      chk("model.sin256", lut_amp(10'd256, 1'b1), 2047);
      chk("model.sin128", lut_amp(10'd128, 1'b1), 1447);

      // Reset state.
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      chk("reset.dac_code", bus0.dac_code, 2048);
      chk("reset.pulse_idx", bus0.pulse_idx, 0);

      // Flat tone group: samples on edges 2..9 and 22..29.
      gd_cnt = 0;
      step(0, 1, 0);
      for (int i = 1; i <= 45; i++) begin
         step(0, 0, 0);
         if (bus0.group_done) gd_cnt++;
         if (i >= 2 && i <= 9) begin
            chk("tone.tx_I", bus0.tx_I, lit_i[(i - 2) % 4]);
            chk("tone.tx_Q", bus0.tx_Q, lit_q[(i - 2) % 4]);
         end
         if (i == 2) begin
            chk("tone.pulse_start0", bus0.pulse_start, 1);
            chk("tone.dac_max", bus0.dac_code, 4095);
         end
         if (i == 4) chk("tone.dac_min", bus0.dac_code, 1);
         if (i == 10) chk("tone.valid_end", bus0.tx_valid, 0);
         if (i == 22) begin
            chk("tone.pulse_start1", bus0.pulse_start, 1);
            chk("tone.pulse_idx1", bus0.pulse_idx, 1);
         end
      end
      chk("tone.group_done_count", gd_cnt, 1);
      chk("tone.busy_after", bus0.busy, 0);

      // start held high: groups every 42 edges, pulse starts at 2,22,44,64,86.
      ps_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(0, 1, 0);
         if (bus0.pulse_start) ps_cnt++;
      end
      chk("held.pulse_starts", ps_cnt, 5);
      step(0, 0, 1);

      // Abort mid-pulse, abort again while idle, then restart from pulse 0.
      step(0, 1, 0);
      for (int i = 1; i <= 4; i++) step(0, 0, 0);
      step(0, 0, 1);
      chk("stop.tx_valid", bus0.tx_valid, 0);
      chk("stop.dac_code", bus0.dac_code, 2048);
      chk("stop.busy", bus0.busy, 0);
      for (int i = 6; i <= 14; i++) step(0, 0, 0);
      step(0, 0, 1);
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("restart.tx_I", bus0.tx_I, 2047);
      chk("restart.tx_Q", bus0.tx_Q, 0);
      chk("restart.pulse_idx", bus0.pulse_idx, 0);
      chk("restart.pulse_start", bus0.pulse_start, 1);
      for (int i = 0; i < 45; i++) step(0, 0, 0);

      // Reset inside LISTEN, then start+stop together, then all three together.
      step(0, 1, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0);
      step(1, 0, 0);
      chk("rst.busy", bus1.busy, 0);
      chk("rst.tx_valid", bus1.tx_valid, 0);
      chk("rst.tx_I", bus1.tx_I, 0);
      chk("rst.dac_code", bus1.dac_code, 2048);
      step(0, 1, 1);
      chk("startstop.busy", bus1.busy, 0);
      step(1, 1, 1);
      chk("rststartstop.busy", bus1.busy, 0);
      step(0, 0, 0);
      chk("startstop.stay_idle", bus1.busy, 0);

      // Randomized control traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(299) == 0, $urandom_range(7) == 0, $urandom_range(99) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
